dm_port_arbiter: RTL

Arbitrates one data-memory port between two requesters: requester 0 is the CPU MEM stage, requester 1 is an auxiliary master such as a debug loader or DMA. Each access runs a three-state sequence that checks alignment and range, drives byte enables and lane-shifted write data to the DM, and returns load data already lane-extracted and sign- or zero-extended. It sits between the MEM stage / system bridge and the DM macro, and replaces direct CPU-to-DM wiring.

---
 rtl/dm_pkg.sv | 41 ++++
 rtl/dm_port_arbiter_be_decoder.sv | 34 +++
 rtl/dm_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory port arbiter.
// Mode codes, FSM states, captured request bundle and DM size default.
package dm_pkg;

  localparam int unsigned DM_SIZE_BYTES_DEFAULT = 12288;

  typedef enum logic [3:0] {
    MODE_WORD  = 4'd0,
    MODE_HALF  = 4'd1,
    MODE_HALFU = 4'd2,
    MODE_BYTE  = 4'd3,
    MODE_BYTEU = 4'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } dmarb_state_e;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mode;
  } dm_req_t;

  function automatic logic mode_legal(input logic [3:0] m);
    return m <= MODE_BYTEU;
  endfunction

  function automatic logic mode_is_half(input logic [3:0] m);
    return (m == MODE_HALF) || (m == MODE_HALFU);
  endfunction

  function automatic logic mode_is_byte(input logic [3:0] m);
    return (m == MODE_BYTE) || (m == MODE_BYTEU);
  endfunction

endpackage

// File: rtl/dm_port_arbiter_be_decoder.sv
// dm_port_arbiter_be_decoder: byte enables and misalignment flag
// from the low address bits and access mode.
module dm_port_arbiter_be_decoder
  import dm_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [3:0] mode,
  output logic [3:0] be,
  output logic       misalign
);

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    unique case (1'b1)
      mode == MODE_WORD: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      mode_is_half(mode): begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      mode_is_byte(mode): begin
        be = 4'b0001 << addr_lo;
      end
      default: begin
        be       = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one DM port between CPU MEM stage and an aux master.
// DMARB_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has priority.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned DM_SIZE_BYTES = DM_SIZE_BYTES_DEFAULT
) (
  input  logic        DMARB_i_clk,
  input  logic        DMARB_i_rst_n,
  input  logic [1:0]  DMARB_i_Valid,
  input  logic        DMARB_i_We0,
  input  logic        DMARB_i_We1,
  input  logic [31:0] DMARB_i_Addr0,
  input  logic [31:0] DMARB_i_Addr1,
  input  logic [31:0] DMARB_i_Wdata0,
  input  logic [31:0] DMARB_i_Wdata1,
  input  logic [3:0]  DMARB_i_Mode0,
  input  logic [3:0]  DMARB_i_Mode1,
  output logic [1:0]  DMARB_o_Ready,
  output logic [1:0]  DMARB_o_RespValid,
  output logic [31:0] DMARB_o_Rdata,
  output logic        DMARB_o_Err,
  output logic        DMARB_o_DmEn,
  output logic        DMARB_o_DmWe,
  output logic [31:0] DMARB_o_DmAddr,
  output logic [3:0]  DMARB_o_DmBe,
  output logic [31:0] DMARB_o_DmWdata,
  input  logic [31:0] DMARB_i_DmRdata
);

  dmarb_state_e state_q;
  dm_req_t      req_q;
  dm_req_t      req_in;
  logic [1:0]   grant;
  logic         accept;
  logic         acc_id;
  logic [3:0]   be_dec;
  logic         misalign;
  logic         out_of_range;
  logic         err;
  logic         issue_ok;
  logic         in_resp;
  logic [7:0]   b_lane;
  logic [15:0]  h_lane;
  logic [31:0]  ld_ext;
  logic [31:0]  st_lane;

`ifdef DMARB_ROUND_ROBIN_EN
  logic rr_q;

  always_comb begin
    grant = DMARB_i_Valid;
    if (&DMARB_i_Valid) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge DMARB_i_clk or negedge DMARB_i_rst_n) begin
    if (!DMARB_i_rst_n) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= ~acc_id;
    end
  end
`else
  assign grant = {DMARB_i_Valid[1] & ~DMARB_i_Valid[0],
                  DMARB_i_Valid[0]};
`endif

  // Ready is also held low while reset is asserted.
  assign DMARB_o_Ready = (state_q == ST_IDLE && DMARB_i_rst_n)
                       ? grant : 2'b00;
  assign accept = |(DMARB_o_Ready & DMARB_i_Valid);
  assign acc_id = DMARB_o_Ready[1];

  always_comb begin
    req_in.id = acc_id;
    if (acc_id) begin
      req_in.we    = DMARB_i_We1;
      req_in.addr  = DMARB_i_Addr1;
      req_in.wdata = DMARB_i_Wdata1;
      req_in.mode  = DMARB_i_Mode1;
    end else begin
      req_in.we    = DMARB_i_We0;
      req_in.addr  = DMARB_i_Addr0;
      req_in.wdata = DMARB_i_Wdata0;
      req_in.mode  = DMARB_i_Mode0;
    end
  end

  always_ff @(posedge DMARB_i_clk or negedge DMARB_i_rst_n) begin
    if (!DMARB_i_rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_ISSUE;
            req_q   <= req_in;
          end
        end
        ST_ISSUE: state_q <= ST_RESP;
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  dm_port_arbiter_be_decoder u_be_dec (
    .addr_lo  (req_q.addr[1:0]),
    .mode     (req_q.mode),
    .be       (be_dec),
    .misalign (misalign)
  );

  assign out_of_range = req_q.addr >= 32'(DM_SIZE_BYTES);
  assign err = ~mode_legal(req_q.mode) | misalign | out_of_range;

  assign issue_ok = (state_q == ST_ISSUE) && !err;
  assign in_resp  = (state_q == ST_RESP);

  always_comb begin
    st_lane = 32'h0;
    unique case (1'b1)
      req_q.mode == MODE_WORD:  st_lane = req_q.wdata;
      mode_is_half(req_q.mode): st_lane = {2{req_q.wdata[15:0]}};
      mode_is_byte(req_q.mode): st_lane = {4{req_q.wdata[7:0]}};
      default:                  st_lane = 32'h0;
    endcase
  end

  assign DMARB_o_DmEn    = issue_ok;
  assign DMARB_o_DmWe    = issue_ok & req_q.we;
  assign DMARB_o_DmAddr  = issue_ok ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign DMARB_o_DmBe    = issue_ok ? be_dec : 4'b0000;
  assign DMARB_o_DmWdata = issue_ok ? st_lane : 32'h0;

  // Lane extraction works on the word the DM returns this cycle.
  assign b_lane = 8'(DMARB_i_DmRdata >> {req_q.addr[1:0], 3'b000});
  assign h_lane = req_q.addr[1] ? DMARB_i_DmRdata[31:16]
                                : DMARB_i_DmRdata[15:0];

  always_comb begin
    ld_ext = 32'h0;
    unique case (1'b1)
      req_q.mode == MODE_WORD:  ld_ext = DMARB_i_DmRdata;
      req_q.mode == MODE_HALF:  ld_ext = {{16{h_lane[15]}}, h_lane};
      req_q.mode == MODE_HALFU: ld_ext = {16'h0, h_lane};
      req_q.mode == MODE_BYTE:  ld_ext = {{24{b_lane[7]}}, b_lane};
      req_q.mode == MODE_BYTEU: ld_ext = {24'h0, b_lane};
      default:                  ld_ext = 32'h0;
    endcase
  end

  assign DMARB_o_RespValid = in_resp ? (req_q.id ? 2'b10 : 2'b01)
                                     : 2'b00;
  assign DMARB_o_Err   = in_resp & err;
  assign DMARB_o_Rdata = (in_resp && !err && !req_q.we) ? ld_ext
                                                        : 32'h0;

endmodule
